// File: rtl/ex_muldiv_unit_if.sv
// EX-stage multiply/divide port bundle: issue, HI/LO move controls and unit status.
// The master side is the pipeline/hazard logic, the slave side is the unit.
interface ex_muldiv_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             i_start;
    logic [1:0]       i_op;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_mf_rd;
    logic             i_mf_sel;
    logic             i_mt_wr;
    logic [WIDTH-1:0] i_mt_data;
    logic [WIDTH-1:0] o_mf_data;
    logic [WIDTH-1:0] o_hi;
    logic [WIDTH-1:0] o_lo;
    logic             o_busy;
    logic             o_stall;
    logic             o_done;
    logic             o_div_by_zero;

    modport master (
        output i_start, i_op, i_a, i_b, i_mf_rd, i_mf_sel, i_mt_wr, i_mt_data,
        input  o_mf_data, o_hi, o_lo, o_busy, o_stall, o_done, o_div_by_zero
    );

    modport slave (
        input  i_start, i_op, i_a, i_b, i_mf_rd, i_mf_sel, i_mt_wr, i_mt_data,
        output o_mf_data, o_hi, o_lo, o_busy, o_stall, o_done, o_div_by_zero
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding architectural HI/LO.
// Works on operand magnitudes (one bit per cycle) and fixes signs in a final cycle.
module ex_muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    ex_muldiv_unit_if.slave    bus
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned W2 = 2 * WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_is_div;
    logic            r_neg_res;
    logic            r_neg_rem;
    logic [WIDTH-1:0] r_opnd;
    logic [W2-1:0]   r_acc;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic            r_busy;
    logic            r_done;
    logic            r_dbz;

    logic             w_is_div;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic             w_b_zero;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_div_sub;
    logic [W2-1:0]    w_prod;
    logic [WIDTH-1:0] w_quo;
    logic [WIDTH-1:0] w_rem;

    // Operand decode: signed ops work on magnitudes
    assign w_is_div = bus.i_op[1];
    assign w_a_neg  = bus.i_op[0] & bus.i_a[WIDTH-1];
    assign w_b_neg  = bus.i_op[0] & bus.i_b[WIDTH-1];
    assign w_mag_a  = w_a_neg ? -bus.i_a : bus.i_a;
    assign w_mag_b  = w_b_neg ? -bus.i_b : bus.i_b;
    assign w_b_zero = (bus.i_b == '0);

    // Multiply: acc = {partial product, remaining multiplier bits}
    assign w_mul_sum = {1'b0, r_acc[W2-1:WIDTH]} + {1'b0, (r_acc[0] ? r_opnd : WIDTH'(0))};
    // Divide: acc = {partial remainder, dividend bits / quotient bits}; top bit of w_div_sub flags a borrow
    assign w_div_sub = r_acc[W2-1:WIDTH-1] - {1'b0, r_opnd};

    assign w_prod = r_neg_res ? -r_acc : r_acc;
    assign w_quo  = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem  = r_neg_rem ? -r_acc[W2-1:WIDTH] : r_acc[W2-1:WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_opnd    <= '0;
            r_acc     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_dbz     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.i_start) begin
                        r_is_div  <= w_is_div;
                        r_opnd    <= w_is_div ? w_mag_b : w_mag_a;
                        r_acc     <= {WIDTH'(0), (w_is_div ? w_mag_a : w_mag_b)};
                        r_neg_res <= w_a_neg ^ w_b_neg;
                        r_neg_rem <= w_a_neg;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_dbz     <= w_is_div & w_b_zero;
                        r_state   <= (w_is_div & w_b_zero) ? S_FIX : S_RUN;
                    end else if (bus.i_mt_wr) begin
                        if (bus.i_mf_sel) r_hi <= bus.i_mt_data;
                        else              r_lo <= bus.i_mt_data;
                    end
                end
                S_RUN: begin
                    if (r_is_div) begin
                        if (!w_div_sub[WIDTH])
                            r_acc <= {w_div_sub[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
                        else
                            r_acc <= {r_acc[W2-2:0], 1'b0};
                    end else begin
                        r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
                    end
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(WIDTH - 1)) r_state <= S_FIX;
                end
                S_FIX: begin
                    // A divide by zero leaves HI/LO untouched
                    if (!r_dbz) begin
                        if (r_is_div) begin
                            r_hi <= w_rem;
                            r_lo <= w_quo;
                        end else begin
                            r_hi <= w_prod[W2-1:WIDTH];
                            r_lo <= w_prod[WIDTH-1:0];
                        end
                    end
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_mf_data     = bus.i_mf_sel ? r_hi : r_lo;
    assign bus.o_stall       = r_busy & (bus.i_start | bus.i_mf_rd | bus.i_mt_wr);
    assign bus.o_hi          = r_hi;
    assign bus.o_lo          = r_lo;
    assign bus.o_busy        = r_busy;
    assign bus.o_done        = r_done;
    assign bus.o_div_by_zero = r_dbz;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: cycle-level reference model plus
// directed vectors with hand-computed HI/LO results.
module tb_ex_muldiv_unit;
    localparam int unsigned WIDTH = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passed = 0;
    bit   run_cmp = 1'b0;

    ex_muldiv_unit_if #(.WIDTH(WIDTH)) ifc ();

    ex_muldiv_unit #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        else passed++;
    endtask

    // Architectural result from plain arithmetic: {hi, lo}
    function automatic logic [63:0] model_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'b00: res = {32'b0, a} * {32'b0, b};
            2'b01: res = 64'(sa * sb);
            2'b10: res = {a % b, a / b};
            default: begin
                q = sa / sb;
                r = sa % sb;
                res = {32'(r), 32'(q)};
            end
        endcase
        return res;
    endfunction

    // Reference model: op accepted at E0 commits WIDTH+1 edges later (1 edge for divide by zero)
    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    logic        m_busy, m_done, m_dbz;
    int          m_left;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_hi <= '0; m_lo <= '0; m_phi <= '0; m_plo <= '0;
            m_busy <= 1'b0; m_done <= 1'b0; m_dbz <= 1'b0; m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    if (!m_dbz) begin
                        m_hi <= m_phi;
                        m_lo <= m_plo;
                    end
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                end
            end else if (ifc.i_start) begin
                m_busy <= 1'b1;
                if (ifc.i_op[1] && ifc.i_b == 32'd0) begin
                    m_dbz  <= 1'b1;
                    m_left <= 1;
                end else begin
                    m_dbz  <= 1'b0;
                    m_left <= WIDTH + 1;
                    {m_phi, m_plo} <= model_res(ifc.i_op, ifc.i_a, ifc.i_b);
                end
            end else if (ifc.i_mt_wr) begin
                if (ifc.i_mf_sel) m_hi <= ifc.i_mt_data;
                else              m_lo <= ifc.i_mt_data;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (run_cmp) begin
            chk("hi", 64'(ifc.o_hi), 64'(m_hi));
            chk("lo", 64'(ifc.o_lo), 64'(m_lo));
            chk("busy", 64'(ifc.o_busy), 64'(m_busy));
            chk("done", 64'(ifc.o_done), 64'(m_done));
            chk("div_by_zero", 64'(ifc.o_div_by_zero), 64'(m_dbz));
            chk("stall", 64'(ifc.o_stall),
                64'(m_busy & (ifc.i_start | ifc.i_mf_rd | ifc.i_mt_wr)));
            if (!m_busy)
                chk("mf_data", 64'(ifc.o_mf_data), 64'(ifc.i_mf_sel ? m_hi : m_lo));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(output int nb);
        bit seen;
        seen = 1'b0;
        nb = 0;
        for (int n = 0; n < 40; n++) begin
            if (ifc.o_busy) nb++;
            if (ifc.o_done) begin
                seen = 1'b1;
                break;
            end
            cyc();
        end
        if (!seen) chk("done_timeout", 64'(0), 64'(1));
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, output int nb);
        ifc.i_op    = op;
        ifc.i_a     = a;
        ifc.i_b     = b;
        ifc.i_start = 1'b1;
        cyc();
        ifc.i_start = 1'b0;
        wait_done(nb);
    endtask

    task automatic op_expect(input string nm, input logic [1:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        int nb;
        run_op(op, a, b, nb);
        chk({nm, "_hi"}, 64'(ifc.o_hi), 64'(ehi));
        chk({nm, "_lo"}, 64'(ifc.o_lo), 64'(elo));
        chk({nm, "_busy_cycles"}, 64'(nb), 64'(WIDTH + 1));
    endtask

    task automatic mt(input logic sel, input logic [31:0] d);
        ifc.i_mf_sel  = sel;
        ifc.i_mt_data = d;
        ifc.i_mt_wr   = 1'b1;
        cyc();
        ifc.i_mt_wr   = 1'b0;
    endtask

    initial begin
        int nb;
        ifc.i_start = 1'b0; ifc.i_op = 2'b00; ifc.i_a = '0; ifc.i_b = '0;
        ifc.i_mf_rd = 1'b0; ifc.i_mf_sel = 1'b0; ifc.i_mt_wr = 1'b0; ifc.i_mt_data = '0;
        rst = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
        cyc();
        run_cmp = 1'b1;

        chk("rst_hi", 64'(ifc.o_hi), 64'(0));
        chk("rst_lo", 64'(ifc.o_lo), 64'(0));
        chk("rst_busy", 64'(ifc.o_busy), 64'(0));
        chk("rst_done", 64'(ifc.o_done), 64'(0));
        chk("rst_dbz", 64'(ifc.o_div_by_zero), 64'(0));

        op_expect("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        op_expect("mult_neg3x5", 2'b01, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        op_expect("mult_min_sq", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
        op_expect("div_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        op_expect("div_7_m2", 2'b11, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
        op_expect("div_m7_m2", 2'b11, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3);
        op_expect("divu_100_7", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14);
        op_expect("div_min_m1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);

        // Divide by zero keeps HI/LO and finishes in one iteration
        mt(1'b1, 32'h11);
        mt(1'b0, 32'h22);
        run_op(2'b10, 32'd5, 32'd0, nb);
        chk("dbz_flag", 64'(ifc.o_div_by_zero), 64'(1));
        chk("dbz_busy_cycles", 64'(nb), 64'(1));
        chk("dbz_hi", 64'(ifc.o_hi), 64'(32'h11));
        chk("dbz_lo", 64'(ifc.o_lo), 64'(32'h22));
        op_expect("multu_3x4", 2'b00, 32'd3, 32'd4, 32'd0, 32'd12);
        chk("dbz_cleared", 64'(ifc.o_div_by_zero), 64'(0));

        // MFHI held in EX during a multiply; MTHI and a new start are ignored while busy
        ifc.i_op = 2'b00; ifc.i_a = 32'h1234_5678; ifc.i_b = 32'h10;
        ifc.i_start = 1'b1;
        cyc();
        ifc.i_start = 1'b0;
        repeat (4) cyc();
        ifc.i_mf_rd = 1'b1; ifc.i_mf_sel = 1'b1;
        #1 chk("stall_mf", 64'(ifc.o_stall), 64'(1));
        ifc.i_mt_wr = 1'b1; ifc.i_mt_data = 32'hDEAD;
        ifc.i_start = 1'b1; ifc.i_op = 2'b11; ifc.i_a = 32'd1; ifc.i_b = 32'd0;
        repeat (3) cyc();
        ifc.i_mt_wr = 1'b0; ifc.i_start = 1'b0;
        wait_done(nb);
        chk("mf_new_hi", 64'(ifc.o_mf_data), 64'(32'h1));
        chk("mf_lo", 64'(ifc.o_lo), 64'(32'h2345_6780));
        chk("mf_no_dbz", 64'(ifc.o_div_by_zero), 64'(0));
        ifc.i_mf_rd = 1'b0;
        cyc();

        mt(1'b0, 32'hABCD);
        chk("mtlo", 64'(ifc.o_lo), 64'(32'hABCD));

        // Asynchronous reset in the middle of an iteration
        ifc.i_op = 2'b01; ifc.i_a = 32'd9; ifc.i_b = 32'd9;
        ifc.i_start = 1'b1;
        cyc();
        ifc.i_start = 1'b0;
        repeat (9) cyc();
        #1 rst = 1'b1;
        #1;
        chk("arst_busy", 64'(ifc.o_busy), 64'(0));
        chk("arst_hi", 64'(ifc.o_hi), 64'(0));
        chk("arst_lo", 64'(ifc.o_lo), 64'(0));
        chk("arst_done", 64'(ifc.o_done), 64'(0));
        cyc();
        rst = 1'b0;
        cyc();
        op_expect("divu_after_rst", 2'b10, 32'd1000, 32'd10, 32'd0, 32'd100);

        repeat (3) cyc();
        run_cmp = 1'b0;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
